serial_alu_seq: RTL
===================

Name: serial_alu_seq

Overview:
Bit-serial add/subtract sequencer that time-shares one Full_adder cell across all operand bits, LSB first, one bit per clock. It captures operands on a start request, runs WIDTH iterations through the shared adder with a registered carry, then presents the registered result and flags with a one-cycle done pulse. It is the low-area arithmetic path of the ALU, used where a parallel ripple adder is not needed.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset; clears all state and outputs
start  input  1  operation request; sampled only in IDLE
A  input  WIDTH  operand A, captured on accepted start
B  input  WIDTH  operand B, captured on accepted start
Sub  input  1  0 = A+B, 1 = A-B; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; Result/flags valid from this cycle
Result  output  WIDTH  registered sum/difference, held until next completion
Cout  output  1  carry out of MSB (for Sub: 1 = no borrow)
Ovf  output  1  signed two's-complement overflow
Zero  output  1  1 when Result == 0

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, Result, Cout, Ovf, Zero = 0; shift registers, bit counter, carry FF = 0. An operation in progress is abandoned; no done pulse is generated for it.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> load a_sr=A, b_sr=(Sub ? ~B : B), carry FF=Sub, cnt=0; go to RUN. start=0 -> stay.
- RUN: Full_adder inputs = a_sr[0], b_sr[0], carry FF. Each edge: a_sr, b_sr shift right by 1; sum bit enters r_sr at MSB (r_sr shifts right); carry FF <= adder Carry; cnt++. On the edge processing bit WIDTH-1 (cnt==WIDTH-1): also record cin_msb = carry FF value before update; go to DONE.
- Result registers: on the transition RUN->DONE, Result <= final shifted sum, Cout <= adder Carry of MSB, Ovf <= cin_msb XOR Cout, Zero <= (final sum == 0). Written only there; held otherwise.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: start accepted at E0; bits processed at E1..EWIDTH; done high in the cycle after EWIDTH (WIDTH=8: done visible after edge 8, IDLE after edge 9). Earliest next accept at E(WIDTH+2) if start held high.
- start in RUN or DONE is ignored (not queued). A, B, Sub changes after E0 have no effect on the operation in progress.
- Flags from a previous operation stay valid through the whole next RUN; they update only at its completion.
- Arithmetic is modulo 2^WIDTH; subtraction is A + ~B + 1.
- busy = (state != IDLE); done = (state == DONE); both decoded from registered state, glitch-free.

Test Plan:
- Reset, then start with A=0x3C, B=0x15, Sub=0 -> done after edge 8, Result=0x51, Cout=0, Ovf=0, Zero=0; busy high for 9 cycles.
- A=0xFF, B=0x01, Sub=0 -> Result=0x00, Cout=1, Ovf=0, Zero=1.
- A=0x7F, B=0x01, Sub=0 -> Result=0x80, Cout=0, Ovf=1; then A=0x80, B=0x01, Sub=1 -> Result=0x7F, Cout=1, Ovf=1.
- A=0x05, B=0x07, Sub=1 -> Result=0xFE, Cout=0 (borrow), Ovf=0, Zero=0.
- Start 0x10+0x20; during RUN pulse start and change A to 0xAA -> no restart, Result=0x30, exactly one done pulse; start held high continuously -> back-to-back operations accepted every WIDTH+2 cycles.
- Start 0x3C+0x15, assert rst after bit 4 -> all outputs 0 immediately, no done; release rst, start 0x01+0x01 -> Result=0x02 normally.

Source files
------------

// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the bit-serial add/subtract sequencer.
// The master drives the operation request; the slave returns status and result.
interface serial_alu_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (output start, A, B, Sub,
                  input  busy, done, Result, Cout, Ovf, Zero);
  modport slave  (input  start, A, B, Sub,
                  output busy, done, Result, Cout, Ovf, Zero);
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract: one shared full-adder cell, LSB first, one bit per clock.
// Result and flags are registered at completion and held until the next one.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_alu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_r_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_ovf, r_zero;

  // Shared full-adder cell
  logic             w_sum, w_carry, w_last;
  logic [WIDTH-1:0] w_r_next;

  assign w_sum    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry  = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
  assign w_r_next = {w_sum, r_r_sr[WIDTH-1:1]};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1
          r_a_sr  <= bus.A;
          r_b_sr  <= bus.Sub ? ~bus.B : bus.B;
          r_carry <= bus.Sub;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_r_sr  <= w_r_next;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry here is the carry into the MSB
            r_result <= w_r_next;
            r_cout   <= w_carry;
            r_ovf    <= r_carry ^ w_carry;
            r_zero   <= (w_r_next == '0);
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.Result = r_result;
  assign bus.Cout   = r_cout;
  assign bus.Ovf    = r_ovf;
  assign bus.Zero   = r_zero;
endmodule
